tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, per-requester FIFO depth in bytes; it SHALL be a power of two, at least 2.
REQ-002 Port: clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; it SHALL be sampled only on a rising clk edge.
REQ-004 Port: a_req  input  1  requester A write strobe; one byte per high cycle.
REQ-005 Port: a_data  input  8  requester A byte, valid while a_req=1.
REQ-006 Port: a_busy  output  1  FIFO A full; A SHALL NOT assert a_req while a_busy=1.
REQ-007 Ports: b_req, b_data, b_busy SHALL have the same directions, widths and meanings as the A ports, for requester B.
REQ-008 Port: tx_req  output  1  one-cycle send pulse to the UART transmitter.
REQ-009 Port: tx_data  output  8  byte for the transmitter.
REQ-010 Port: tx_busy  input  1  transmitter busy flag.
REQ-011 Port: grant  output  1  source of the last issued byte (0=A, 1=B).

Function
REQ-012 Each requester SHALL have its own DEPTH-entry circular FIFO with read pointer, write pointer and a count of width log2(DEPTH)+1; pointers SHALL wrap from DEPTH-1 to 0.
REQ-013 A byte SHALL be written when x_req=1 and the FIFO is not full; x_req while full SHALL be ignored, with no pointer or count change.
REQ-014 x_busy SHALL equal (count==DEPTH), combinational from the registered count.
REQ-015 A write and a pop on the same FIFO in the same cycle SHALL both take effect and leave the count unchanged; when the FIFO is full in that cycle, the write SHALL be ignored and only the pop taken.
REQ-016 The FSM states SHALL be IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-017 IDLE: when tx_busy=0 and at least one FIFO is non-empty, the FSM SHALL pop one byte into a data register, set grant to the chosen source and go to ISSUE. Otherwise it SHALL stay in IDLE.
REQ-018 Arbitration, single source non-empty: that source SHALL be chosen.
REQ-019 Arbitration, both sources non-empty: the source not equal to the current grant SHALL be chosen (round-robin).
REQ-020 ISSUE: tx_req=1 for exactly this one cycle; the FSM SHALL then go to WAIT_HI.
REQ-021 WAIT_HI: when tx_busy=1 the FSM SHALL go to WAIT_LO. If tx_busy stays 0 for 4 consecutive WAIT_HI cycles, it SHALL go to IDLE, using a 2-bit timeout counter cleared on entry to WAIT_HI.
REQ-022 WAIT_LO: when tx_busy=0 the FSM SHALL go to IDLE.
REQ-023 tx_data SHALL be driven from the data register and held stable from ISSUE until the next pop.
REQ-024 tx_req SHALL be 0 in every state except ISSUE.
REQ-025 Latency: with both FIFOs empty, the FSM in IDLE and tx_busy=0, a_req in cycle t SHALL produce tx_req=1 in cycle t+2.
REQ-026 At most one byte SHALL be outstanding at the transmitter; no pop SHALL occur outside IDLE.
REQ-027 Requester writes SHALL be accepted in every FSM state.

Reset
REQ-028 While reset=0 at a clk edge, the block SHALL set: all pointers and counts 0; FSM to IDLE; data register 0; grant=1 (so A wins the first tie); the timeout counter to 0.
REQ-029 During and after reset: tx_req=0, tx_data=0x00, a_busy=0, b_busy=0.
REQ-030 Reset mid-operation SHALL discard all queued bytes. If tx_busy is still 1 after reset, the FSM SHALL stay in IDLE until tx_busy=0.

Verification
REQ-031 Single byte: a_req, a_data=0x41 at cycle t with the block idle -> tx_req=1 and tx_data=0x41 at t+2, grant=0; transmitter model raises busy at t+3 for 10 cycles -> FSM back in IDLE the cycle after busy falls.
REQ-032 Round-robin: A queues 0x11,0x12 and B queues 0x21,0x22 while tx_busy=1 -> after release, issue order 0x11,0x21,0x12,0x22.
REQ-033 Full/wrap: DEPTH=4, tx_busy held 1, A writes 0x01..0x05 -> a_busy=1 after the 4th write, 0x05 dropped. Release, then write 0x06,0x07 -> output 0x01,0x02,0x03,0x04,0x06,0x07 (pointer wrap exercised).
REQ-034 Simultaneous write/pop: FIFO A holds 1 byte, a_req coincides with the IDLE pop -> count stays 1 and both bytes are sent in order.
REQ-035 Timeout and reset: transmitter model never raises busy -> FSM returns to IDLE 4 cycles after ISSUE. Reset=0 for 1 cycle with 3 bytes queued and tx_busy=1 -> FIFOs empty, tx_req stays 0 until busy falls and a new a_req arrives.

Source files
------------

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - two-requester round-robin byte arbiter feeding a UART transmitter
// Each requester owns a small circular FIFO; one byte at a time is handed to the transmitter.
module tx_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_req,
   input  logic [7:0] a_data,
   output logic       a_busy,
   input  logic       b_req,
   input  logic [7:0] b_data,
   output logic       b_busy,
   output logic       tx_req,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       grant
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_HI = 2'd2;
   localparam logic [1:0] S_WAIT_LO = 2'd3;

   logic [7:0]    a_mem_q [DEPTH];
   logic [7:0]    a_mem_d [DEPTH];
   logic [7:0]    b_mem_q [DEPTH];
   logic [7:0]    b_mem_d [DEPTH];
   logic [AW-1:0] a_rd_ptr_q, a_rd_ptr_d, a_wr_ptr_q, a_wr_ptr_d;
   logic [AW-1:0] b_rd_ptr_q, b_rd_ptr_d, b_wr_ptr_q, b_wr_ptr_d;
   logic [AW:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [1:0]    tmo_q, tmo_d;
   logic [7:0]    data_q, data_d;
   logic          grant_q, grant_d;

   logic a_wr, b_wr, pop_a, pop_b, a_ne, b_ne, pick_b;

   assign a_busy  = (a_cnt_q == FULL);
   assign b_busy  = (b_cnt_q == FULL);
   assign tx_req  = (state_q == S_ISSUE);
   assign tx_data = data_q;
   assign grant   = grant_q;

   always_comb begin
      a_wr   = a_req && !a_busy;
      b_wr   = b_req && !b_busy;
      a_ne   = (a_cnt_q != '0);
      b_ne   = (b_cnt_q != '0);
      // On a tie the source that did not win last time goes next.
      pick_b = (a_ne && b_ne) ? !grant_q : b_ne;
      pop_a   = 1'b0;
      pop_b   = 1'b0;
      state_d = state_q;
      tmo_d   = tmo_q;
      data_d  = data_q;
      grant_d = grant_q;
      case (state_q)
         S_IDLE: begin
            if (!tx_busy && (a_ne || b_ne)) begin
               pop_a   = !pick_b;
               pop_b   = pick_b;
               data_d  = pick_b ? b_mem_q[b_rd_ptr_q] : a_mem_q[a_rd_ptr_q];
               grant_d = pick_b;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d   = 2'd0;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end else if (tmo_q == 2'd3) begin
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 2'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      a_mem_d    = a_mem_q;
      b_mem_d    = b_mem_q;
      a_wr_ptr_d = a_wr_ptr_q;
      b_wr_ptr_d = b_wr_ptr_q;
      a_rd_ptr_d = pop_a ? a_rd_ptr_q + AW'(1) : a_rd_ptr_q;
      b_rd_ptr_d = pop_b ? b_rd_ptr_q + AW'(1) : b_rd_ptr_q;
      if (a_wr) begin
         a_mem_d[a_wr_ptr_q] = a_data;
         a_wr_ptr_d          = a_wr_ptr_q + AW'(1);
      end
      if (b_wr) begin
         b_mem_d[b_wr_ptr_q] = b_data;
         b_wr_ptr_d          = b_wr_ptr_q + AW'(1);
      end
      case ({a_wr, pop_a})
         2'b10:   a_cnt_d = a_cnt_q + (AW + 1)'(1);
         2'b01:   a_cnt_d = a_cnt_q - (AW + 1)'(1);
         default: a_cnt_d = a_cnt_q;
      endcase
      case ({b_wr, pop_b})
         2'b10:   b_cnt_d = b_cnt_q + (AW + 1)'(1);
         2'b01:   b_cnt_d = b_cnt_q - (AW + 1)'(1);
         default: b_cnt_d = b_cnt_q;
      endcase
   end

   // Storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_rd_ptr_q <= '0;
         a_wr_ptr_q <= '0;
         b_rd_ptr_q <= '0;
         b_wr_ptr_q <= '0;
         a_cnt_q    <= '0;
         b_cnt_q    <= '0;
         state_q    <= S_IDLE;
         tmo_q      <= 2'd0;
         data_q     <= 8'h00;
         grant_q    <= 1'b1;
      end else begin
         a_rd_ptr_q <= a_rd_ptr_d;
         a_wr_ptr_q <= a_wr_ptr_d;
         b_rd_ptr_q <= b_rd_ptr_d;
         b_wr_ptr_q <= b_wr_ptr_d;
         a_cnt_q    <= a_cnt_d;
         b_cnt_q    <= b_cnt_d;
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         data_q     <= data_d;
         grant_q    <= grant_d;
      end
   end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed self-checking bench for tx_arbiter
module tb_tx_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       a_req = 1'b0;
   logic [7:0] a_data = 8'h00;
   logic       a_busy;
   logic       b_req = 1'b0;
   logic [7:0] b_data = 8'h00;
   logic       b_busy;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;
   logic       grant;

   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] got_data[$];
   logic       got_grant[$];

   tx_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_data(a_data), .a_busy(a_busy),
      .b_req(b_req), .b_data(b_data), .b_busy(b_busy),
      .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_req = 1'b0;
      b_req = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   // Transmitter model: busy rises the cycle after tx_req and lasts blen cycles.
   task automatic collect(input int n, input int blen);
      int pend = 0;
      int cnt = 0;
      int cyc = 0;
      got_data.delete();
      got_grant.delete();
      tx_busy = 1'b0;
      while ((got_data.size() < n || pend != 0 || cnt != 0) && cyc < 400) begin
         step();
         cyc++;
         if (pend != 0) begin
            tx_busy = 1'b1;
            cnt = blen;
            pend = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) tx_busy = 1'b0;
         end
         if (tx_req === 1'b1) begin
            got_data.push_back(tx_data);
            got_grant.push_back(grant);
            pend = 1;
         end
      end
      n_checks++;
      if (got_data.size() != n) begin
         n_fail++;
         $display("FAIL collect_count: got %0d bytes, want %0d", got_data.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
      n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
      n_checks++; if (grant !== 1'b1) begin n_fail++; $display("FAIL rst_grant: got %b want 1", grant); end
      reset = 1'b1;
      step();
      n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_tx_req: got %b want 0", tx_req); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL post_rst_tx_data: got %h want 00", tx_data); end
   endtask

   task automatic test_single();
      a_req = 1'b1;
      a_data = 8'h41;
      step();
      a_req = 1'b0;
      n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL single_t1_tx_req: got %b want 0", tx_req); end
      step();
      n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL single_t2_tx_req: got %b want 1", tx_req); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_t2_tx_data: got %h want 41", tx_data); end
      n_checks++; if (grant !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b want 0", grant); end
      for (int k = 3; k <= 15; k++) begin
         step();
         tx_busy = (k <= 12);
         a_req = (k == 5);
         a_data = 8'h42;
         n_checks++;
         if (tx_req !== (k == 15)) begin
            n_fail++;
            $display("FAIL single_busy_release t+%0d tx_req: got %b want %b", k, tx_req, (k == 15));
         end
         n_checks++;
         if (tx_data !== ((k == 15) ? 8'h42 : 8'h41)) begin
            n_fail++;
            $display("FAIL single_hold t+%0d tx_data: got %h want %h", k, tx_data, (k == 15) ? 8'h42 : 8'h41);
         end
      end
      a_req = 1'b0;
      tx_busy = 1'b0;
      for (int k = 0; k < 8; k++) step();
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_d [4] = '{8'h11, 8'h21, 8'h12, 8'h22};
      logic       exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      tx_busy = 1'b1;
      a_req = 1'b1; a_data = 8'h11; b_req = 1'b1; b_data = 8'h21;
      step();
      a_data = 8'h12; b_data = 8'h22;
      step();
      a_req = 1'b0; b_req = 1'b0;
      collect(4, 3);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_grant[i] !== exp_g[i]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %h/%b want %h/%b", i,
                     (i < got_data.size()) ? got_data[i] : 8'hxx,
                     (i < got_grant.size()) ? got_grant[i] : 1'bx, exp_d[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_full_wrap();
      logic [7:0] exp_d [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07};
      logic [7:0] all_d [$];
      do_reset();
      tx_busy = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         a_req = 1'b1;
         a_data = 8'(i);
         step();
         if (i >= 3) begin
            n_checks++;
            if (a_busy !== (i >= 4)) begin
               n_fail++;
               $display("FAIL full_a_busy after write %0d: got %b want %b", i, a_busy, (i >= 4));
            end
         end
      end
      a_req = 1'b0;
      collect(4, 2);
      all_d = got_data;
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL full_drained_a_busy: got %b want 0", a_busy); end
      tx_busy = 1'b1;
      a_req = 1'b1; a_data = 8'h06;
      step();
      a_data = 8'h07;
      step();
      a_req = 1'b0;
      collect(2, 2);
      all_d = {all_d, got_data};
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (i >= all_d.size() || all_d[i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: got %h want %h", i, (i < all_d.size()) ? all_d[i] : 8'hxx, exp_d[i]);
         end
      end
   endtask

   task automatic test_simul_write_pop();
      logic [7:0] exp_d [4] = '{8'h32, 8'h33, 8'h34, 8'h35};
      do_reset();
      tx_busy = 1'b1;
      a_req = 1'b1; a_data = 8'h31;
      step();
      tx_busy = 1'b0;
      a_data = 8'h32;
      step();
      n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL simul_issue tx_req: got %b want 1", tx_req); end
      n_checks++; if (tx_data !== 8'h31) begin n_fail++; $display("FAIL simul_issue tx_data: got %h want 31", tx_data); end
      tx_busy = 1'b1;
      a_data = 8'h33;
      step();
      a_data = 8'h34;
      step();
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL simul_count3 a_busy: got %b want 0", a_busy); end
      a_data = 8'h35;
      step();
      n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL simul_count4 a_busy: got %b want 1", a_busy); end
      a_req = 1'b0;
      collect(4, 2);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_data.size() || got_data[i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL simul_order[%0d]: got %h want %h", i, (i < got_data.size()) ? got_data[i] : 8'hxx, exp_d[i]);
         end
      end
   endtask

   task automatic test_timeout();
      tx_busy = 1'b0;
      step();
      step();
      a_req = 1'b1; a_data = 8'h51;
      step();
      a_data = 8'h52;
      step();
      a_req = 1'b0;
      n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL tmo_issue1 tx_req: got %b want 1", tx_req); end
      n_checks++; if (tx_data !== 8'h51) begin n_fail++; $display("FAIL tmo_issue1 tx_data: got %h want 51", tx_data); end
      for (int k = 3; k <= 8; k++) begin
         step();
         n_checks++;
         if (tx_req !== (k == 8)) begin
            n_fail++;
            $display("FAIL tmo t+%0d tx_req: got %b want %b", k, tx_req, (k == 8));
         end
      end
      n_checks++; if (tx_data !== 8'h52) begin n_fail++; $display("FAIL tmo_issue2 tx_data: got %h want 52", tx_data); end
      for (int k = 0; k < 8; k++) step();
   endtask

   task automatic test_reset_mid();
      tx_busy = 1'b1;
      a_req = 1'b1; a_data = 8'h61; b_req = 1'b1; b_data = 8'h71;
      step();
      a_data = 8'h62; b_req = 1'b0;
      step();
      a_req = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
      n_checks++; if (grant !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got %b want 1", grant); end
      n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_b_busy: got %b want 0", b_busy); end
      for (int k = 0; k < 10; k++) begin
         if (k == 4) tx_busy = 1'b0;
         step();
         n_checks++;
         if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet cycle %0d tx_req: got %b want 0", k, tx_req); end
      end
      a_req = 1'b1; a_data = 8'h81;
      step();
      a_req = 1'b0;
      step();
      n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL rmid_new tx_req: got %b want 1", tx_req); end
      n_checks++; if (tx_data !== 8'h81) begin n_fail++; $display("FAIL rmid_new tx_data: got %h want 81", tx_data); end
      n_checks++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rmid_new grant: got %b want 0", grant); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_wrap();
      test_simul_write_pop();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
